clock_step_ctrl: RTL and testbench
==================================

Name: clock_step_ctrl

Overview:
- Run/halt/single-step controller for the core clock.
- Replaces a free-running divided clock with a one-cycle clock-enable pulse at a programmable rate.
- The core and debug logic can run, halt, or issue N step ticks; a breakpoint input forces a halt.
- Sits between the board clock and the core's clock-enabled pipeline registers.

Parameters:
- DIV_WIDTH, 16: width of divide value.
- STEP_WIDTH, 8: width of step count.
- DEFAULT_DIV, 2: divide value loaded at reset. Tick period is DEFAULT_DIV+1 cycles.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- div_i  in  DIV_WIDTH  new divide value; period = div_i+1 cycles.
- div_load_i  in  1  latch div_i into div_q.
- run_i  in  1  request free-run.
- halt_i  in  1  request halt.
- step_i  in  1  request a step burst.
- step_count_i  in  STEP_WIDTH  ticks per burst; 0 treated as 1.
- brk_i  in  1  breakpoint from core; forces halt.
- clk_en_o  out  1  one-cycle tick enable.
- phase_o  out  1  toggles on every tick (divided-clock view).
- state_o  out  2  current state encoding.
- halted_o  out  1  state==HALTED.
- done_o  out  1  one-cycle pulse when a step burst completes.

Behaviour:
- Reset: state=HALTED, counter=0, remaining=0, div_q=DEFAULT_DIV, clk_en_o=0, phase_o=0, done_o=0.
- States: HALTED=0, RUN=1, STEP=2.
- Priority per edge: rst > halt_i > brk_i > step_i > run_i.
- Tick condition: state is RUN/STEP, counter==div_q, and no halt_i/brk_i this cycle.
  - On a tick edge: clk_en_o<=1, phase_o<=~phase_o, counter<=0.
  - Otherwise in RUN/STEP: counter<=counter+1 and clk_en_o<=0.
- Counter is held at 0 in HALTED.
- Latency: first clk_en_o is visible div_q+1 edges after the edge that samples run_i/step_i. Subsequent ticks follow every div_q+1 cycles (div_q=0 gives a tick every cycle).
- HALTED:
  - step_i -> STEP, remaining<=max(step_count_i,1).
  - Otherwise run_i -> RUN.
  - If both are high, step_i wins.
- RUN:
  - halt_i or brk_i -> HALTED next edge; no tick in that cycle, even on a counter match.
  - run_i and step_i are ignored.
- STEP:
  - Each tick decrements remaining.
  - A tick with remaining==1 sets state<=HALTED and done_o<=1 on the same edge as the last clk_en_o.
  - halt_i or brk_i -> HALTED without done_o; remaining<=0.
  - step_i and run_i are ignored.
- div_load_i: div_q<=div_i and counter<=0 on the same edge (period restarts). This suppresses a tick coinciding with the load. It is legal in any state.
- phase_o holds its level while halted.
- done_o and clk_en_o are never high for more than one consecutive cycle, except clk_en_o when div_q=0.
- rst in any state, including mid-burst, restores all reset values, including div_q.
- Counter width is DIV_WIDTH. The compare is equality, so no wrap occurs while div_q is static.

Optional Feature:
- Macro CLKCTRL_TICK_COUNT_EN.
- Defined: adds output tick_count_o (32 bits).
  - Increments on every clk_en_o assertion.
  - Reset 0; wraps 0xFFFFFFFF->0.
  - Not cleared by halt.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package clk_ctrl_pkg:
  - State encoding constants ST_HALTED, ST_RUN, ST_STEP (2 bits).
  - Default width constants for DIV_WIDTH and STEP_WIDTH.
- Sub-module clk_ctrl_tick_gen:
  - Contains counter, compare, restart on load/enable-drop, and the registered tick/phase outputs.
  - Inputs: enable, div_q, restart.
  - The top level keeps the FSM, remaining count and done_o.

Test Plan:
- Reset, then idle 20 cycles -> clk_en_o=0, halted_o=1, state_o=0, phase_o=0.
- Default div 2; pulse run_i at edge E -> clk_en_o high at E+3, E+6, E+9; phase_o toggles at each.
- While running, load div_i=0 -> tick every cycle after the next edge. Then load 5 -> ticks 6 cycles apart, first 6 edges after the load.
- div 1, step_count_i=4 -> exactly 4 ticks, 2 cycles apart; done_o coincides with the 4th tick; then halted. Repeat with step_count_i=0 -> exactly 1 tick plus done_o.
- halt_i asserted on a counter-match cycle in RUN -> no tick, state HALTED next edge. brk_i in STEP with remaining=3 -> HALTED, no done_o, no further ticks.
- rst asserted mid-STEP after a div_load of 7 -> all outputs at reset values; a following run_i ticks every 3 cycles (div_q=DEFAULT_DIV).

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding and default widths for the run/halt/single-step clock controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam int DEF_DIV_WIDTH  = 16;
  localparam int DEF_STEP_WIDTH = 8;

endpackage

// File: rtl/clk_ctrl_tick_gen.sv
// Programmable-period tick generator: counts to div_q, emits a registered one-cycle enable
// and a phase bit that toggles on every tick.
module clk_ctrl_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div_q,
  output logic                 tick,
  output logic                 clk_en,
  output logic                 phase
);

  logic [DIV_WIDTH-1:0] count_q;

  // A load restarts the period, so a match on the load edge never ticks.
  assign tick = enable && !restart && (count_q == div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      clk_en  <= 1'b0;
      phase   <= 1'b0;
    end else begin
      clk_en <= tick;
      if (tick) begin
        phase <= ~phase;
      end
      if (!enable || restart || tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Run/halt/single-step controller producing a one-cycle core clock enable at a programmable rate.
// Optional CLKCTRL_TICK_COUNT_EN adds a free-running 32-bit count of emitted ticks.
module clock_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int STEP_WIDTH  = DEF_STEP_WIDTH,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  div_load_i,
  input  logic                  run_i,
  input  logic                  halt_i,
  input  logic                  step_i,
  input  logic [STEP_WIDTH-1:0] step_count_i,
  input  logic                  brk_i,
  output logic                  clk_en_o,
  output logic                  phase_o,
  output logic [1:0]            state_o,
  output logic                  halted_o,
  output logic                  done_o
`ifdef CLKCTRL_TICK_COUNT_EN
  ,
  output logic [31:0]           tick_count_o
`endif
);

  // Requests are plain levels sampled on every edge; there is no handshake, and a request
  // that the current state ignores is simply dropped.
  state_t                state_q, state_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic                  done_d;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  stop_req;
  logic                  active;
  logic                  tick;

  assign stop_req = halt_i | brk_i;
  assign active   = (state_q != ST_HALTED) && !stop_req;

  clk_ctrl_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (active),
    .restart(div_load_i),
    .div_q  (div_q),
    .tick   (tick),
    .clk_en (clk_en_o),
    .phase  (phase_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALTED;
      remaining_q <= '0;
      done_o      <= 1'b0;
      div_q       <= DIV_WIDTH'(DEFAULT_DIV);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_o      <= done_d;
      if (div_load_i) begin
        div_q <= div_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (!stop_req) begin
          if (step_i) begin
            state_d     = ST_STEP;
            remaining_d = (step_count_i == '0) ? STEP_WIDTH'(1) : step_count_i;
          end else if (run_i) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (stop_req) begin
          state_d     = ST_HALTED;
          remaining_d = '0;
        end else if (tick) begin
          remaining_d = remaining_q - STEP_WIDTH'(1);
          // Last tick of the burst: done lands on the same edge as the final enable.
          if (remaining_q == STEP_WIDTH'(1)) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_HALTED;
        remaining_d = '0;
      end
    endcase
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALTED);

`ifdef CLKCTRL_TICK_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count_o <= '0;
    end else if (tick) begin
      tick_count_o <= tick_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Self-checking bench for clock_step_ctrl: expected tick/done cycles are queued when stimulus
// is driven and retired cycle by cycle against clk_en_o, done_o and phase_o.
module tb_clock_step_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] div_i;
  logic        div_load_i;
  logic        run_i;
  logic        halt_i;
  logic        step_i;
  logic [7:0]  step_count_i;
  logic        brk_i;
  logic        clk_en_o;
  logic        phase_o;
  logic [1:0]  state_o;
  logic        halted_o;
  logic        done_o;
`ifdef CLKCTRL_TICK_COUNT_EN
  logic [31:0] tick_count_o;
`endif

  clock_step_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .div_i       (div_i),
    .div_load_i  (div_load_i),
    .run_i       (run_i),
    .halt_i      (halt_i),
    .step_i      (step_i),
    .step_count_i(step_count_i),
    .brk_i       (brk_i),
    .clk_en_o    (clk_en_o),
    .phase_o     (phase_o),
    .state_o     (state_o),
    .halted_o    (halted_o),
    .done_o      (done_o)
`ifdef CLKCTRL_TICK_COUNT_EN
    ,
    .tick_count_o(tick_count_o)
`endif
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_tq[$];
  logic [31:0] exp_dq[$];
  logic [31:0] cyc;
  logic        exp_phase;
  logic [31:0] exp_tcnt;
  int          vectors;
  int          miscompares;

  // Advance one edge, then retire scoreboard entries due on that edge.
  task automatic tick_cycle();
    logic exp_tick;
    logic exp_done;
    @(posedge clk);
    cyc = cyc + 32'd1;
    #1;
    if (rst) begin
      exp_phase = 1'b0;
      exp_tcnt  = '0;
    end
    exp_tick = (exp_tq.size() > 0) && (exp_tq[0] == cyc);
    exp_done = (exp_dq.size() > 0) && (exp_dq[0] == cyc);
    if (exp_tick) begin
      void'(exp_tq.pop_front());
      exp_phase = ~exp_phase;
      exp_tcnt  = exp_tcnt + 32'd1;
    end
    if (exp_done) void'(exp_dq.pop_front());
    vectors++;
    if (clk_en_o !== exp_tick) begin
      miscompares++;
      $display("FAIL clk_en cycle %0d: got %b, expected %b", cyc, clk_en_o, exp_tick);
    end
    vectors++;
    if (done_o !== exp_done) begin
      miscompares++;
      $display("FAIL done cycle %0d: got %b, expected %b", cyc, done_o, exp_done);
    end
    vectors++;
    if (phase_o !== exp_phase) begin
      miscompares++;
      $display("FAIL phase cycle %0d: got %b, expected %b", cyc, phase_o, exp_phase);
    end
`ifdef CLKCTRL_TICK_COUNT_EN
    vectors++;
    if (tick_count_o !== exp_tcnt) begin
      miscompares++;
      $display("FAIL tick_count cycle %0d: got %0d, expected %0d", cyc, tick_count_o, exp_tcnt);
    end
`endif
  endtask

  // driver tasks
  task automatic pulse_run();
    run_i = 1'b1;
    tick_cycle();
    run_i = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_i = 1'b1;
    tick_cycle();
    halt_i = 1'b0;
  endtask

  task automatic load_div(input logic [15:0] d);
    div_i      = d;
    div_load_i = 1'b1;
    tick_cycle();
    div_load_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic check_halted(input string tag);
    vectors++;
    if (halted_o !== 1'b1 || state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL %s halted: got halted=%b state=%0d, expected halted=1 state=0",
               tag, halted_o, state_o);
    end
  endtask

  task automatic check_drained(input string tag);
    vectors++;
    if (exp_tq.size() != 0 || exp_dq.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d ticks and %0d dones still expected, expected 0 and 0",
               tag, exp_tq.size(), exp_dq.size());
    end
  endtask

  // test tasks
  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    vectors++;
    if (clk_en_o !== 1'b0 || phase_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b ph=%b done=%b, expected 0 0 0",
               clk_en_o, phase_o, done_o);
    end
    check_halted("reset");
    wait_cycles(20);
    check_halted("reset_idle");
  endtask

  task automatic test_run_default();
    logic [31:0] e;
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd3);
    exp_tq.push_back(e + 32'd6);
    exp_tq.push_back(e + 32'd9);
    pulse_run();
    vectors++;
    if (state_o !== 2'd1) begin
      miscompares++;
      $display("FAIL run_state: got %0d, expected 1", state_o);
    end
    wait_cycles(9);
    pulse_halt();
    check_halted("run_default");
    wait_cycles(4);
    check_drained("run_default");
  endtask

  task automatic test_div_load();
    logic [31:0] e;
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd3);
    pulse_run();
    wait_cycles(3);
    e = cyc + 32'd1;
    for (int i = 1; i <= 5; i++) exp_tq.push_back(e + 32'(i));
    load_div(16'd0);
    wait_cycles(5);
    // this load lands on a match edge with div 0; the tick must be suppressed
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd6);
    exp_tq.push_back(e + 32'd12);
    load_div(16'd5);
    wait_cycles(12);
    pulse_halt();
    check_halted("div_load");
    check_drained("div_load");
  endtask

  task automatic test_step();
    logic [31:0] e;
    load_div(16'd1);
    e = cyc + 32'd1;
    for (int i = 1; i <= 4; i++) exp_tq.push_back(e + 32'(2 * i));
    exp_dq.push_back(e + 32'd8);
    step_count_i = 8'd4;
    step_i       = 1'b1;
    tick_cycle();
    step_i = 1'b0;
    vectors++;
    if (state_o !== 2'd2) begin
      miscompares++;
      $display("FAIL step_state: got %0d, expected 2", state_o);
    end
    wait_cycles(8);
    check_halted("step4");
    wait_cycles(4);
    // count 0 acts as 1; run_i alongside must lose to step_i
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd2);
    exp_dq.push_back(e + 32'd2);
    step_count_i = 8'd0;
    step_i       = 1'b1;
    run_i        = 1'b1;
    tick_cycle();
    step_i = 1'b0;
    run_i  = 1'b0;
    wait_cycles(2);
    check_halted("step0");
    wait_cycles(5);
    check_drained("step");
  endtask

  task automatic test_halt_brk();
    logic [31:0] e;
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd2);
    exp_tq.push_back(e + 32'd4);
    pulse_run();
    wait_cycles(5);
    pulse_halt();
    check_halted("halt_on_match");
    wait_cycles(4);
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd2);
    exp_tq.push_back(e + 32'd4);
    step_count_i = 8'd5;
    step_i       = 1'b1;
    tick_cycle();
    step_i = 1'b0;
    wait_cycles(5);
    brk_i = 1'b1;
    tick_cycle();
    brk_i = 1'b0;
    check_halted("brk_in_step");
    wait_cycles(8);
    check_drained("halt_brk");
  endtask

  task automatic test_reset_mid_step();
    logic [31:0] e;
    load_div(16'd7);
    step_count_i = 8'd3;
    step_i       = 1'b1;
    tick_cycle();
    step_i = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    tick_cycle();
    rst = 1'b0;
    vectors++;
    if (clk_en_o !== 1'b0 || phase_o !== 1'b0 || done_o !== 1'b0 || state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got en=%b ph=%b done=%b st=%0d, expected 0 0 0 0",
               clk_en_o, phase_o, done_o, state_o);
    end
    wait_cycles(10);
    e = cyc + 32'd1;
    exp_tq.push_back(e + 32'd3);
    exp_tq.push_back(e + 32'd6);
    exp_tq.push_back(e + 32'd9);
    pulse_run();
    wait_cycles(9);
    pulse_halt();
    check_halted("post_reset_run");
    check_drained("reset_mid_step");
  endtask

  initial begin
    rst          = 1'b1;
    div_i        = '0;
    div_load_i   = 1'b0;
    run_i        = 1'b0;
    halt_i       = 1'b0;
    step_i       = 1'b0;
    step_count_i = '0;
    brk_i        = 1'b0;
    cyc          = '0;
    exp_phase    = 1'b0;
    exp_tcnt     = '0;
    vectors      = 0;
    miscompares  = 0;
    test_reset();
    test_run_default();
    test_div_load();
    test_step();
    test_halt_brk();
    test_reset_mid_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
